// File: rtl/sync_mux_arbiter_pkg.sv
// sync_mux_arbiter_pkg
// Shared definitions for the sync_mux_arbiter slice:
//   - arb_state_e : FSM state encoding (IDLE, HOLD, SETTLE, RELEASE)
//   - clog2       : ceiling log2, never smaller than 1 so vectors stay legal
//   - max2        : larger of two integers, used to size the phase counter
package sync_mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_mux_rr_pick.sv
// sync_mux_rr_pick
// Purely combinational round-robin picker. The search starts at last+1 and
// wraps from requesters-1 back to 0, so the previous winner has the lowest
// priority.
// Ports:
//   req    [requesters-1:0] in  request vector
//   last   [gw-1:0]         in  index of the previous winner
//   winner [gw-1:0]         out chosen index (meaningful only when any=1)
//   any                     out at least one request is set
module sync_mux_rr_pick #(
  parameter int requesters = 4,
  parameter int gw         = 2
) (
  input  logic [requesters-1:0] req,
  input  logic [gw-1:0]         last,
  output logic [gw-1:0]         winner,
  output logic                  any
);

  int          pos;
  logic [gw-1:0] idx;

  // Walk from the farthest candidate to the nearest one; the last hit
  // (the nearest after 'last') overwrites earlier ones and wins.
  always_comb begin
    winner = last;
    any    = |req;
    pos    = 0;
    idx    = '0;
    for (int k = requesters; k >= 1; k--) begin
      pos = int'(last) + k;
      if (pos >= requesters) pos = pos - requesters;
      idx = gw'(pos);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/sync_mux_arbiter.sv
// sync_mux_arbiter
// Round-robin arbiter feeding a mux-style clock-domain-crossing synchronizer.
// A winning word is registered onto mux_din and announced with mux_din_valid
// for 'hold' cycles; the data then stays stable for 'settle' more cycles so
// the destination can capture it safely.
//
// Handshake: a requester presents req_valid with its word on req_data; the
// word is taken in the single IDLE cycle in which req_ready for that
// requester is high (combinational, one-hot). Nothing is queued: a request
// that is not accepted must still be asserted when the block returns to IDLE.
//
// Optional feature: macro SYNC_MUX_ARB_ACK_EN adds port mux_ack, a
// stages-deep synchronizer producing ack_s, and a RELEASE state (HOLD waits
// for ack_s=1, RELEASE waits for ack_s=0 before SETTLE).
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req_valid      in   [requesters]        per-requester request
//   req_data       in   [requesters*width]  word i at [i*width +: width]
//   req_ready      out  [requesters]        one-hot accept pulse
//   mux_din        out  [width]             registered data to the synchronizer
//   mux_din_valid  out                      registered valid to the synchronizer
//   grant          out  [clog2(requesters)] last accepted requester
//   busy           out                      state is not IDLE
//   mux_ack        in                       destination ack (ACK_EN builds only)
module sync_mux_arbiter
  import sync_mux_arbiter_pkg::*;
#(
  parameter int width      = 32,
  parameter int requesters = 4,
  parameter int stages     = 2,
  parameter int hold       = 4,
  parameter int settle     = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [requesters-1:0]         req_valid,
  input  logic [requesters*width-1:0]   req_data,
  output logic [requesters-1:0]         req_ready,
  output logic [width-1:0]              mux_din,
  output logic                          mux_din_valid,
  output logic [clog2(requesters)-1:0]  grant,
  output logic                          busy
`ifdef SYNC_MUX_ARB_ACK_EN
  ,input  logic                         mux_ack
`endif
);

  localparam int GW = clog2(requesters);
  localparam int CW = clog2(max2(hold, settle) + 1);

  arb_state_e    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          accept;
  logic [width-1:0] sel_word;

  sync_mux_rr_pick #(
    .requesters (requesters),
    .gw         (GW)
  ) u_pick (
    .req    (req_valid),
    .last   (grant),
    .winner (winner),
    .any    (any_req)
  );

  always_comb sel_word = req_data[winner*width +: width];

`ifdef SYNC_MUX_ARB_ACK_EN
  logic [stages-1:0] ack_sync;
  logic              ack_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[stages-2:0], mux_ack};
  end

  assign ack_s = ack_sync[stages-1];
`endif

  // Next-state logic. The counter is loaded on entry to a timed state and
  // counts down to 0, where it rests until the state is left.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    req_ready  = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = ST_HOLD;
          cnt_next          = CW'(hold - 1);
        end
      end
      ST_HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end
`ifdef SYNC_MUX_ARB_ACK_EN
        else if (ack_s) begin
          state_next = ST_RELEASE;
        end
`else
        else begin
          state_next = ST_SETTLE;
          cnt_next   = CW'(settle - 1);
        end
`endif
      end
`ifdef SYNC_MUX_ARB_ACK_EN
      ST_RELEASE: begin
        if (!ack_s) begin
          state_next = ST_SETTLE;
          cnt_next   = CW'(settle - 1);
        end
      end
`endif
      ST_SETTLE: begin
        if (cnt != '0) cnt_next = cnt - 1'b1;
        else           state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mux_din       <= '0;
      mux_din_valid <= 1'b0;
      grant         <= GW'(requesters - 1);
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      // Valid is high exactly while the registered state is HOLD.
      mux_din_valid <= (state_next == ST_HOLD);
      if (accept) begin
        mux_din <= sel_word;
        grant   <= winner;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sync_mux_arbiter.sv
// tb_sync_mux_arbiter
// Bench for sync_mux_arbiter with width=8, requesters=4, stages=2, hold=4,
// settle=3. A reference model tracks "cycles since last accept", the last
// winner and the last word, and every sampled cycle is compared against it.
module tb_sync_mux_arbiter;

  localparam int W      = 8;
  localparam int N      = 4;
  localparam int HOLD   = 4;
  localparam int SETTLE = 3;

  logic           clock;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mux_din;
  logic           mux_din_valid;
  logic [1:0]     grant;
  logic           busy;
`ifdef SYNC_MUX_ARB_ACK_EN
  logic           mux_ack;
  assign mux_ack = mux_din_valid;
`endif

  sync_mux_arbiter #(
    .width      (W),
    .requesters (N),
    .stages     (2),
    .hold       (HOLD),
    .settle     (SETTLE)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .mux_din       (mux_din),
    .mux_din_valid (mux_din_valid),
    .grant         (grant),
    .busy          (busy)
`ifdef SYNC_MUX_ARB_ACK_EN
    ,.mux_ack      (mux_ack)
`endif
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / scoreboard ----------------
  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  // reference model state
  int       m_since;   // cycles since the last accept (large = idle)
  int       m_last;    // last winner
  logic [W-1:0] m_data;
  logic     prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_since    = 1000;
    m_last     = N - 1;
    m_data     = '0;
    prev_valid = 1'b0;
    exp_q.delete();
  endtask

  // Compare this cycle's outputs against the model, then advance the model
  // with the inputs the DUT will see at the next rising edge.
  task automatic model_check();
    int           w;
    logic         e_busy;
    logic         e_valid;
    logic [N-1:0] e_rdy;
    e_busy  = (m_since >= 1) && (m_since <= HOLD + SETTLE);
    e_valid = (m_since >= 1) && (m_since <= HOLD);
    w       = e_busy ? -1 : rr_winner(req_valid, m_last);
    e_rdy   = '0;
    if (w >= 0) e_rdy[w] = 1'b1;
    check("m_busy",  32'(busy),          32'(e_busy));
    check("m_valid", 32'(mux_din_valid), 32'(e_valid));
    check("m_ready", 32'(req_ready),     32'(e_rdy));
    check("m_grant", 32'(grant),         32'(m_last));
    check("m_din",   32'(mux_din),       32'(m_data));
    if (mux_din_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_word actual=%0h expected=<none> at %0t", mux_din, $time);
      end else begin
        check("sb_word", 32'(mux_din), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = mux_din_valid;
    if (w >= 0) begin
      m_last  = w;
      m_data  = req_data[w*W +: W];
      m_since = 1;
      exp_q.push_back(m_data);
    end else if (m_since < 1000) begin
      m_since++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clock);
    model_check();
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] exp_rdy;
    logic [1:0]   exp_grant;
  } vec_t;

  vec_t vecs[10];
  int   acc_cyc[$];
  int   acc_who[$];

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    // table, starting from last grant = 1 (after the single-request sequence)
    vecs[0] = '{4'b0010, 4'b0010, 2'd1};
    vecs[1] = '{4'b1111, 4'b0100, 2'd2};
    vecs[2] = '{4'b0001, 4'b0001, 2'd0};
    vecs[3] = '{4'b1001, 4'b1000, 2'd3};
    vecs[4] = '{4'b1001, 4'b0001, 2'd0};
    vecs[5] = '{4'b0110, 4'b0010, 2'd1};
    vecs[6] = '{4'b0000, 4'b0000, 2'd1};
    vecs[7] = '{4'b1110, 4'b0100, 2'd2};
    vecs[8] = '{4'b1011, 4'b1000, 2'd3};
    vecs[9] = '{4'b0110, 4'b0010, 2'd1};

    // ---------------- reset ----------------
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_din",   32'(mux_din),       32'h0);
    check("rst_valid", 32'(mux_din_valid), 32'h0);
    check("rst_grant", 32'(grant),         32'(N - 1));
    check("rst_busy",  32'(busy),          32'h0);
    check("rst_ready", 32'(req_ready),     32'h0);
    reset_n = 1'b1;
    idle_cycles(2);

    // ---------------- single request, full timeline ----------------
    req_valid = 4'b0010;
    req_data  = {8'h11, 8'h22, 8'hA5, 8'h44};
    sample();
    check("single_ready_c0", 32'(req_ready), 32'b0010);
    advance();
    req_valid = '0;
    req_data  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      sample();
      if (c <= HOLD) begin
        check("single_valid_hold", 32'(mux_din_valid), 32'h1);
        check("single_din_hold",   32'(mux_din),       32'hA5);
      end else if (c <= HOLD + SETTLE) begin
        check("single_valid_settle", 32'(mux_din_valid), 32'h0);
        check("single_din_settle",   32'(mux_din),       32'hA5);
        check("single_busy_settle",  32'(busy),          32'h1);
      end else begin
        check("single_busy_c8", 32'(busy), 32'h0);
      end
      advance();
    end

    // ---------------- table-driven accepts ----------------
    foreach (vecs[i]) begin
      req_valid = vecs[i].rv;
      req_data  = $urandom;
      sample();
      check("tbl_ready", 32'(req_ready), 32'(vecs[i].exp_rdy));
      advance();
      req_valid = '0;
      sample();
      check("tbl_grant", 32'(grant), 32'(vecs[i].exp_grant));
      advance();
      if (vecs[i].exp_rdy != '0) idle_cycles(HOLD + SETTLE - 1);
    end

    // ---------------- request changes while busy ----------------
    req_valid = 4'b0001;          // last grant 1 -> requester 0 wins
    req_data  = $urandom;
    sample();
    check("chg_ready_c0", 32'(req_ready), 32'b0001);
    advance();
    req_valid = 4'b1000;
    for (int c = 1; c <= HOLD + SETTLE; c++) begin
      sample();
      check("chg_ready_busy", 32'(req_ready), 32'h0);
      advance();
    end
    sample();
    check("chg_ready_idle", 32'(req_ready), 32'b1000);
    advance();
    req_valid = '0;
    sample();
    check("chg_grant", 32'(grant), 32'd3);
    advance();
    idle_cycles(HOLD + SETTLE - 1);

    // ---------------- reset in the middle of HOLD ----------------
    req_valid = 4'b0100;
    req_data  = $urandom;
    sample();
    advance();
    req_valid = '0;
    sample();
    advance();                     // now in HOLD cycle 2
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(mux_din_valid), 32'h0);
    check("abort_din",   32'(mux_din),       32'h0);
    check("abort_busy",  32'(busy),          32'h0);
    check("abort_grant", 32'(grant),         32'(N - 1));
    model_reset();
    advance();
    advance();
    reset_n = 1'b1;

    // ---------------- everyone requesting continuously ----------------
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      req_data = $urandom;
      sample();
      if (req_ready != '0) begin
        acc_cyc.push_back(c);
        acc_who.push_back(onehot_idx(req_ready));
      end
      advance();
    end
    check("rr_count", 32'(acc_cyc.size()), 32'd5);
    for (int k = 0; k < 5 && k < acc_cyc.size(); k++) begin
      check("rr_who", 32'(acc_who[k]), 32'(k % N));
      check("rr_cyc", 32'(acc_cyc[k]), 32'(k * (1 + HOLD + SETTLE)));
    end
    req_valid = '0;
    idle_cycles(HOLD + SETTLE + 1);

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 15));
      req_data  = $urandom;
      sample();
      advance();
    end
    req_valid = '0;
    idle_cycles(HOLD + SETTLE + 2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_mux_arbiter.md
SYNC_MUX_ARBITER -- requirements
Module: sync_mux_arbiter

Interface
REQ-001 SHALL have parameter width, default 32, bits per data word.
REQ-002 SHALL have parameter requesters, default 4, number of requester ports (2..16).
REQ-003 SHALL have parameter stages, default 2, destination synchronizer depth (>=2).
REQ-004 SHALL have parameter hold, default 4, cycles mux_din_valid stays high (>=stages+1).
REQ-005 SHALL have parameter settle, default 3, cycles mux_din stays stable after valid drops (>=stages+1).
REQ-006 SHALL have port clock  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port req_valid  in  requesters  per-requester transfer request.
REQ-009 SHALL have port req_data  in  requesters*width  flattened words, requester i at bits [i*width +: width].
REQ-010 SHALL have port req_ready  out  requesters  one-hot accept pulse.
REQ-011 SHALL have port mux_din  out  width  registered data toward the mux synchronizer.
REQ-012 SHALL have port mux_din_valid  out  1  registered control toward the mux synchronizer.
REQ-013 SHALL have port grant  out  clog2(requesters)  index of the last accepted requester.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port mux_ack  in  1  destination-domain acknowledge, present only with SYNC_MUX_ARB_ACK_EN.

Function
REQ-016 SHALL implement states IDLE, HOLD, SETTLE, plus RELEASE when ack is enabled.
REQ-017 In IDLE with any req_valid high, SHALL pick a winner round-robin, starting at grant+1 and wrapping at requesters-1 to 0.
REQ-018 SHALL drive req_ready[winner] combinationally high in that IDLE cycle, load mux_din and grant, and enter HOLD next cycle.
REQ-019 SHALL keep req_ready all-zero outside IDLE, and in IDLE when no req_valid is set.
REQ-020 In HOLD, mux_din_valid SHALL be 1 for exactly hold cycles, then 0 on entry to SETTLE.
REQ-021 In SETTLE, mux_din SHALL stay unchanged for settle cycles, then return to IDLE.
REQ-022 Throughput SHALL be one word per 1+hold+settle cycles, and back-to-back acceptance SHALL occur in the first IDLE cycle.
REQ-023 mux_din SHALL change only on an accept cycle, and never while busy.
REQ-024 Requesters dropping req_valid while the block is busy SHALL have no effect, and no request SHALL be queued.
REQ-025 The counter SHALL be clog2(max(hold,settle)+1) bits wide, load at state entry, and decrement to 0 without wrap.

Reset
REQ-026 On reset_n low, outputs SHALL asynchronously become: mux_din=0, mux_din_valid=0, grant=requesters-1 (so requester 0 has first priority), busy=0, req_ready=0, state IDLE, counter 0.
REQ-027 Reset asserted mid-transfer SHALL abort that transfer with no completion or req_ready pulse, and after release the first accept SHALL follow REQ-017.

Configuration
REQ-028 With macro SYNC_MUX_ARB_ACK_EN defined, mux_ack SHALL pass through a stages-deep flop chain to form ack_s, whose registers reset to 0.
REQ-029 With SYNC_MUX_ARB_ACK_EN defined, HOLD SHALL last for at least hold cycles and until ack_s=1.
REQ-030 With SYNC_MUX_ARB_ACK_EN defined, after HOLD the block SHALL enter RELEASE (valid 0, data stable) until ack_s=0, then run SETTLE.
REQ-031 Without SYNC_MUX_ARB_ACK_EN, mux_ack and the chain SHALL be absent and timing SHALL follow REQ-020/021 exactly.

Structure
REQ-032 Package sync_mux_arbiter_pkg SHALL hold the state encoding constants and the clog2 function.
REQ-033 Round-robin selection SHALL be a sub-module sync_mux_rr_pick (inputs: req vector and last grant; outputs: winner index and any-flag), purely combinational.

Verification (requesters=4, width=8, stages=2, hold=4, settle=3)
REQ-034 Single request: req_valid=0010, data1=0xA5 at cycle 0 -> req_ready=0010 at cycle 0, mux_din=0xA5 and valid=1 for cycles 1-4, valid=0 with data stable for cycles 5-7, busy=0 at cycle 8.
REQ-035 All requesting continuously from reset -> grants in order 0,1,2,3,0, with accepts every 8 cycles.
REQ-036 req_valid changed from 0001 to 1000 during HOLD -> no req_ready until IDLE, and the next grant is 3.
REQ-037 reset_n pulsed low at cycle 2 of HOLD -> mux_din_valid=0 and mux_din=0 immediately, and the next accept is requester 0.
REQ-038 With ACK_EN, mux_ack raised at cycle 10 and dropped at cycle 20 -> valid stays 1 until ack_s rises (cycle 12), RELEASE lasts until cycle 22, then SETTLE runs for 3 cycles.
